// File: rtl/wall_scheduler_pkg.sv
// Shared game package for the VGA wall obstacles.
// Holds coordinate width, screen size, LFSR tap mask and the
// wall_scheduler FSM state encoding.
package wall_scheduler_pkg;
  localparam int          COORD_W   = 11;
  localparam int          SCREEN_W  = 640;
  localparam int          SCREEN_H  = 480;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MOVE  = 2'd1,
    ST_PICK  = 2'd2,
    ST_WRITE = 2'd3
  } wall_state_t;
endpackage

// File: rtl/wall_if.sv
// Wall scheduler bus: game-side controls (enable, frame_tick) and the
// per-slot wall position/valid bus plus event pulses.
//   master : game controller / renderer side (drives enable, frame_tick)
//   slave  : wall_scheduler (drives wall_x/y/valid and pulses)
// wall_x/wall_y pack slot i at [11*i+10:11*i].
interface wall_if
  import wall_scheduler_pkg::*;
#(
  parameter int N_WALLS = 4
);
  logic                              enable;
  logic                              frame_tick;
  logic [N_WALLS-1:0][COORD_W-1:0]   wall_x;
  logic [N_WALLS-1:0][COORD_W-1:0]   wall_y;
  logic [N_WALLS-1:0]                wall_valid;
  logic                              spawn_pulse;
  logic                              retire_pulse;
  logic                              missed_tick;

  modport master (
    output enable, frame_tick,
    input  wall_x, wall_y, wall_valid, spawn_pulse, retire_pulse, missed_tick
  );

  modport slave (
    input  enable, frame_tick,
    output wall_x, wall_y, wall_valid, spawn_pulse, retire_pulse, missed_tick
  );
endinterface

// File: rtl/wall_scheduler_lfsr.sv
// wall_lfsr: free-running 16-bit Galois LFSR.
//   pixel_clk : clock
//   reset     : synchronous active-high, loads SEED
//   lfsr      : current 16-bit state
module wall_lfsr
  import wall_scheduler_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        pixel_clk,
  input  logic        reset,
  output logic [15:0] lfsr
);
  always_ff @(posedge pixel_clk) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end
endmodule

// File: rtl/wall_scheduler.sv
// wall_scheduler: owns the on-screen wall slots. Per enabled frame tick it
// scrolls each live wall left (one slot per cycle), retires walls that left
// the screen, and every SPAWN_PERIOD frames spawns one wall at the right
// edge with an LFSR-chosen gap y.
//   pixel_clk : clock
//   reset     : synchronous, active-high
//   bus       : wall_if slave (enable, frame_tick in; slot bus + pulses out)
module wall_scheduler
  import wall_scheduler_pkg::*;
#(
  parameter int          N_WALLS      = 4,
  parameter int          SCREEN_W     = wall_scheduler_pkg::SCREEN_W,
  parameter int          SPEED        = 2,
  parameter int          SPAWN_PERIOD = 90,
  parameter int          GAP_Y_MIN    = 64,
  parameter int          GAP_Y_MAX    = 352,
  parameter logic [15:0] SEED         = 16'hACE1,
  parameter int          MAX_REJECT   = 16
) (
  input logic   pixel_clk,
  input logic   reset,
  wall_if.slave bus
);
  localparam int IDX_W = (N_WALLS > 1) ? $clog2(N_WALLS) : 1;
  localparam int CNT_W = $clog2(SPAWN_PERIOD + 1);
  localparam int REJ_W = $clog2(MAX_REJECT + 1);

  localparam logic [COORD_W-1:0] SPEED_C  = COORD_W'(SPEED);
  localparam logic [COORD_W-1:0] SCREEN_C = COORD_W'(SCREEN_W);
  localparam logic [COORD_W-1:0] Y_MIN_C  = COORD_W'(GAP_Y_MIN);
  localparam logic [COORD_W-1:0] RANGE_C  = COORD_W'(GAP_Y_MAX - GAP_Y_MIN);
  localparam logic [IDX_W-1:0]   LAST_C   = IDX_W'(N_WALLS - 1);
  localparam logic [CNT_W-1:0]   RELOAD_C = CNT_W'(SPAWN_PERIOD - 1);
  localparam logic [REJ_W-1:0]   REJ_LAST = REJ_W'(MAX_REJECT - 1);

  wall_state_t                     state;
  logic [IDX_W-1:0]                idx;
  logic [CNT_W-1:0]                spawn_cnt;
  logic [REJ_W-1:0]                rej_cnt;
  logic [COORD_W-1:0]              pick_y;
  logic [N_WALLS-1:0][COORD_W-1:0] x_q, y_q;
  logic [N_WALLS-1:0]              v_q;
  logic                            spawn_q, retire_q, missed_q;

  logic [15:0]      lfsr;
  logic [8:0]       sample;
  logic             lfsr_unused;
  logic             accept;
  logic             retire_now;
  logic             has_free;
  logic [IDX_W-1:0] free_idx;

  wall_lfsr #(.SEED(SEED)) u_lfsr (
    .pixel_clk (pixel_clk),
    .reset     (reset),
    .lfsr      (lfsr)
  );

  assign sample      = lfsr[8:0];
  assign lfsr_unused = ^lfsr[15:9];
  assign accept      = ({2'b00, sample} <= RANGE_C);

  // Slot under MOVE retires this cycle; counts as free for the spawn
  // decision made on the last MOVE cycle.
  assign retire_now = v_q[idx] && (x_q[idx] < SPEED_C);
  assign has_free   = (~v_q != '0) || retire_now;

  // Lowest-index free slot.
  always_comb begin
    free_idx = '0;
    for (int i = N_WALLS - 1; i >= 0; i--)
      if (!v_q[i]) free_idx = IDX_W'(i);
  end

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      spawn_cnt <= '0;
      rej_cnt   <= '0;
      pick_y    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      v_q       <= '0;
      spawn_q   <= 1'b0;
      retire_q  <= 1'b0;
      missed_q  <= 1'b0;
    end else begin
      spawn_q  <= 1'b0;
      retire_q <= 1'b0;
      missed_q <= bus.frame_tick && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (bus.frame_tick && bus.enable) begin
            state <= ST_MOVE;
            idx   <= '0;
          end
        end
        ST_MOVE: begin
          if (v_q[idx]) begin
            // x and y are held on retire so the renderer sees the last spot.
            if (x_q[idx] < SPEED_C) begin
              v_q[idx] <= 1'b0;
              retire_q <= 1'b1;
            end else begin
              x_q[idx] <= x_q[idx] - SPEED_C;
            end
          end
          if (idx == LAST_C) begin
            if (spawn_cnt != '0) begin
              spawn_cnt <= spawn_cnt - 1'b1;
              state     <= ST_IDLE;
            end else if (has_free) begin
              rej_cnt <= '0;
              state   <= ST_PICK;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_PICK: begin
          if (accept) begin
            pick_y <= Y_MIN_C + COORD_W'(sample);
            state  <= ST_WRITE;
          end else if (rej_cnt == REJ_LAST) begin
            pick_y <= Y_MIN_C;
            state  <= ST_WRITE;
          end else begin
            rej_cnt <= rej_cnt + 1'b1;
          end
        end
        ST_WRITE: begin
          x_q[free_idx] <= SCREEN_C;
          y_q[free_idx] <= pick_y;
          v_q[free_idx] <= 1'b1;
          spawn_q       <= 1'b1;
          spawn_cnt     <= RELOAD_C;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.wall_x       = x_q;
  assign bus.wall_y       = y_q;
  assign bus.wall_valid   = v_q;
  assign bus.spawn_pulse  = spawn_q;
  assign bus.retire_pulse = retire_q;
  assign bus.missed_tick  = missed_q;
endmodule

// File: tb/tb_wall_scheduler.sv
// Self-checking bench for wall_scheduler. Three instances:
//   u0 : default parameters
//   u1 : SPEED=1, SPAWN_PERIOD=1 (fill/retire/respawn)
//   u2 : GAP_Y_MAX=GAP_Y_MIN=64, SPAWN_PERIOD=1 (reject fallback, reset in PICK)
module tb_wall_scheduler;
  localparam int NW = 4;

  logic pixel_clk;
  logic reset;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  wall_if #(.N_WALLS(NW)) bus0 ();
  wall_if #(.N_WALLS(NW)) bus1 ();
  wall_if #(.N_WALLS(NW)) bus2 ();

  wall_scheduler #(.N_WALLS(NW)) u0 (
    .pixel_clk (pixel_clk), .reset (reset), .bus (bus0));
  wall_scheduler #(.N_WALLS(NW), .SPEED(1), .SPAWN_PERIOD(1)) u1 (
    .pixel_clk (pixel_clk), .reset (reset), .bus (bus1));
  wall_scheduler #(.N_WALLS(NW), .GAP_Y_MAX(64), .SPAWN_PERIOD(1)) u2 (
    .pixel_clk (pixel_clk), .reset (reset), .bus (bus2));

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  always @(posedge pixel_clk) cyc <= cyc + 1;

  // Reference LFSR from the definition: Galois, mask B400, reload ACE1.
  function automatic logic [15:0] lstep(input logic [15:0] v);
    logic [15:0] r;
    r = {1'b0, v[15:1]};
    if (v[0]) r = r ^ 16'hB400;
    return r;
  endfunction

  logic [15:0] m_lfsr;
  always @(posedge pixel_clk) m_lfsr <= reset ? 16'hACE1 : lstep(m_lfsr);

  // l0 is the LFSR value at the edge that accepts the tick; the first PICK
  // sample is NW+1 steps later.
  function automatic void predict(input logic [15:0] l0, input int range,
                                  output int y, output int picks, output int rej);
    logic [15:0] v;
    v = l0;
    for (int k = 0; k < NW + 1; k++) v = lstep(v);
    y = 64; picks = 0; rej = 0;
    for (int p = 0; p < 16; p++) begin
      picks++;
      if (int'(v[8:0]) <= range) begin
        y = 64 + int'(v[8:0]);
        break;
      end
      rej++;
      v = lstep(v);
    end
  endfunction

  typedef struct {
    int inst;
    int slot;
    int y;
    int due;
  } spawn_t;
  spawn_t sq[$];

  typedef struct {
    int         inst;
    int         ticks;
    logic [3:0] valid;
    int         x0;
    int         x3;
    int         ret;
  } vec_t;
  vec_t vt[10];

  int tick_n[3];
  int ret_cnt[3];
  int miss_cnt[3];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_spawn(input int k, input logic [NW-1:0][10:0] wx,
                           input logic [NW-1:0][10:0] wy, input logic [NW-1:0] wv);
    spawn_t e;
    if (sq.size() == 0 || sq[0].inst != k) begin
      total++; bad++;
      $display("FAIL spawn_unexpected: inst %0d pulsed, nothing expected (cyc %0d)", k, cyc);
      return;
    end
    e = sq.pop_front();
    check("spawn_due",   cyc, e.due);
    check("spawn_x",     int'(wx[e.slot]), 640);
    check("spawn_y",     int'(wy[e.slot]), e.y);
    check("spawn_valid", int'(wv[e.slot]), 1);
  endtask

  always @(negedge pixel_clk) begin
    if (bus0.spawn_pulse) chk_spawn(0, bus0.wall_x, bus0.wall_y, bus0.wall_valid);
    if (bus1.spawn_pulse) chk_spawn(1, bus1.wall_x, bus1.wall_y, bus1.wall_valid);
    if (bus2.spawn_pulse) chk_spawn(2, bus2.wall_x, bus2.wall_y, bus2.wall_valid);
    if (bus0.retire_pulse) ret_cnt[0]++;
    if (bus1.retire_pulse) ret_cnt[1]++;
    if (bus2.retire_pulse) ret_cnt[2]++;
    if (bus0.missed_tick) miss_cnt[0]++;
    if (bus1.missed_tick) miss_cnt[1]++;
    if (bus2.missed_tick) miss_cnt[2]++;
  end

  function automatic bit spawn_at(input int k, input int n);
    if (k == 0) return (n == 1 || n == 91 || n == 181 || n == 271);
    if (k == 1) return (n <= 4 || n == 642);
    return 1'b1;
  endfunction

  function automatic int spawn_slot(input int k, input int n);
    if (k == 0) return (n - 1) / 90;
    if (k == 1) return (n <= 4) ? n - 1 : 0;
    return n - 1;
  endfunction

  task automatic set_tick(input int k, input logic v);
    case (k)
      0:       bus0.frame_tick = v;
      1:       bus1.frame_tick = v;
      default: bus2.frame_tick = v;
    endcase
  endtask

  // Called at a negedge; one tick then 24 cycles for the sequence to finish.
  task automatic do_tick(input int k);
    spawn_t e;
    int y, p, r;
    tick_n[k]++;
    if (spawn_at(k, tick_n[k])) begin
      predict(m_lfsr, (k == 2) ? 0 : 288, y, p, r);
      e.inst = k; e.slot = spawn_slot(k, tick_n[k]); e.y = y; e.due = cyc + NW + 2 + p;
      sq.push_back(e);
    end
    set_tick(k, 1'b1);
    @(negedge pixel_clk);
    set_tick(k, 1'b0);
    repeat (23) @(negedge pixel_clk);
    if (sq.size() != 0) begin
      total++; bad++;
      $display("FAIL spawn_missing: inst %0d tick %0d no spawn_pulse within budget", k, tick_n[k]);
      sq.delete();
    end
  endtask

  // Wait until ticking now lands PICK on 16 consecutive rejects for range 0.
  task automatic wait_rej16();
    int y, p, r;
    bit ok;
    ok = 1'b0;
    for (int w = 0; w < 5000 && !ok; w++) begin
      predict(m_lfsr, 0, y, p, r);
      if (r == 16) ok = 1'b1;
      else @(negedge pixel_clk);
    end
    check("rej_window_found", int'(ok), 1);
  endtask

  task automatic get_bus(input int k, output logic [3:0] v, output int x0, output int x3);
    case (k)
      0:       begin v = bus0.wall_valid; x0 = int'(bus0.wall_x[0]); x3 = int'(bus0.wall_x[3]); end
      1:       begin v = bus1.wall_valid; x0 = int'(bus1.wall_x[0]); x3 = int'(bus1.wall_x[3]); end
      default: begin v = bus2.wall_valid; x0 = int'(bus2.wall_x[0]); x3 = int'(bus2.wall_x[3]); end
    endcase
  endtask

  initial begin
    logic [3:0] v;
    int x0, x3;

    // inst, ticks so far, valid mask, slot0 x, slot3 x, retires so far
    vt[0] = '{0,   1, 4'b0001, 640,   0, 0};
    vt[1] = '{0,  90, 4'b0001, 462,   0, 0};
    vt[2] = '{0,  91, 4'b0011, 460,   0, 0};
    vt[3] = '{0, 181, 4'b0111, 280,   0, 0};
    vt[4] = '{0, 271, 4'b1111, 100, 640, 0};
    vt[5] = '{0, 321, 4'b1111,   0, 540, 0};
    vt[6] = '{0, 322, 4'b1110,   0, 538, 1};
    vt[7] = '{1,   4, 4'b1111, 637, 640, 0};
    vt[8] = '{1, 641, 4'b1111,   0,   3, 0};
    vt[9] = '{1, 642, 4'b1111, 640,   2, 1};

    for (int k = 0; k < 3; k++) begin tick_n[k] = 0; ret_cnt[k] = 0; miss_cnt[k] = 0; end
    reset = 1'b1;
    bus0.enable = 1'b1; bus1.enable = 1'b1; bus2.enable = 1'b1;
    bus0.frame_tick = 1'b0; bus1.frame_tick = 1'b0; bus2.frame_tick = 1'b0;
    repeat (4) @(negedge pixel_clk);

    check("rst_valid",  int'(bus0.wall_valid), 0);
    check("rst_x_zero", int'(bus0.wall_x == '0), 1);
    check("rst_y_zero", int'(bus0.wall_y == '0), 1);
    check("rst_pulses", int'({bus0.spawn_pulse, bus0.retire_pulse, bus0.missed_tick}), 0);
    reset = 1'b0;
    @(negedge pixel_clk);

    for (int r = 0; r < 10; r++) begin
      while (tick_n[vt[r].inst] < vt[r].ticks) do_tick(vt[r].inst);
      get_bus(vt[r].inst, v, x0, x3);
      check($sformatf("vec%0d_valid", r),   int'(v), int'(vt[r].valid));
      check($sformatf("vec%0d_x0", r),      x0, vt[r].x0);
      check($sformatf("vec%0d_x3", r),      x3, vt[r].x3);
      check($sformatf("vec%0d_retires", r), ret_cnt[vt[r].inst], vt[r].ret);
    end

    // 16 rejects: fallback y = GAP_Y_MIN, latency NW+2+16 checked by scoreboard.
    wait_rej16();
    do_tick(2);
    check("rej_y",     int'(bus2.wall_y[0]), 64);
    check("rej_valid", int'(bus2.wall_valid), 1);

    // Second tick 3 cycles after the first: one missed_tick, one frame of motion.
    bus0.frame_tick = 1'b1; @(negedge pixel_clk);
    bus0.frame_tick = 1'b0; repeat (2) @(negedge pixel_clk);
    bus0.frame_tick = 1'b1; @(negedge pixel_clk);
    bus0.frame_tick = 1'b0; repeat (22) @(negedge pixel_clk);
    tick_n[0]++;
    check("missed_cnt",   miss_cnt[0], 1);
    check("missed_x3",    int'(bus0.wall_x[3]), 536);
    check("missed_valid", int'(bus0.wall_valid), 4'b1110);

    // Ticks while disabled are ignored entirely.
    bus0.enable = 1'b0;
    repeat (3) begin
      bus0.frame_tick = 1'b1; @(negedge pixel_clk);
      bus0.frame_tick = 1'b0; repeat (23) @(negedge pixel_clk);
    end
    check("dis_x3",     int'(bus0.wall_x[3]), 536);
    check("dis_valid",  int'(bus0.wall_valid), 4'b1110);
    check("dis_missed", miss_cnt[0], 1);
    bus0.enable = 1'b1;

    // Reset while u2 is in PICK: the pending spawn must never appear.
    wait_rej16();
    bus2.frame_tick = 1'b1; @(negedge pixel_clk);
    bus2.frame_tick = 1'b0; repeat (NW + 3) @(negedge pixel_clk);
    reset = 1'b1;
    @(negedge pixel_clk);
    check("rstpick_valid_all", int'({bus2.wall_valid, bus1.wall_valid, bus0.wall_valid}), 0);
    check("rstpick_x2_zero",   int'(bus2.wall_x == '0), 1);
    check("rstpick_y2_zero",   int'(bus2.wall_y == '0), 1);
    check("rstpick_spawn",     int'(bus2.spawn_pulse), 0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) tick_n[k] = 0;
    repeat (30) @(negedge pixel_clk);

    // Post-reset spawn: y follows the reseeded LFSR, FSM accepts the tick.
    do_tick(0);
    check("post_valid", int'(bus0.wall_valid), 4'b0001);
    check("post_x0",    int'(bus0.wall_x[0]), 640);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
